// File: rtl/move_commit.sv
// Commits a one-hot arbiter grant as the current player's move on a 36-cell board.
// Tracks both players' occupancy, alternates turns, and flags illegal grants and a full board.
module move_commit #(
    parameter int unsigned N  = 36,
    parameter int unsigned IW = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  grant,
    input  logic          grant_valid,
    output logic          grant_ready,
    input  logic          new_game,
    output logic [N-1:0]  board_x,
    output logic [N-1:0]  board_o,
    output logic          cur_player,
    output logic [IW-1:0] move_idx,
    output logic          move_valid,
    output logic          err_illegal,
    output logic          board_full
);

    typedef enum logic [1:0] {StAccept, StCheck, StFull} state_e;

    state_e        r_state;
    logic [N-1:0]  r_grant;
    logic [N-1:0]  r_board_x;
    logic [N-1:0]  r_board_o;
    logic          r_cur_player;
    logic [IW-1:0] r_move_idx;
    logic          r_move_valid;
    logic          r_err_illegal;
    logic          r_board_full;

    logic [N-1:0]  w_occupied;
    logic          w_multi;
    logic          w_illegal;
    logic          w_full_after;
    logic [IW-1:0] w_idx;

    assign w_occupied   = r_board_x | r_board_o;
    // Clearing the lowest set bit leaves something only when more than one bit was set.
    assign w_multi      = (r_grant & (r_grant - N'(1))) != '0;
    assign w_illegal    = (r_grant == '0) || w_multi || ((r_grant & w_occupied) != '0);
    assign w_full_after = (w_occupied | r_grant) == '1;

    always_comb begin
        w_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (r_grant[i]) begin
                w_idx = IW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || new_game) begin
            r_state       <= StAccept;
            r_grant       <= '0;
            r_board_x     <= '0;
            r_board_o     <= '0;
            r_cur_player  <= 1'b0;
            r_move_idx    <= '0;
            r_move_valid  <= 1'b0;
            r_err_illegal <= 1'b0;
            r_board_full  <= 1'b0;
        end else begin
            r_move_valid  <= 1'b0;
            r_err_illegal <= 1'b0;
            case (r_state)
                StAccept: begin
                    if (grant_valid) begin
                        r_grant <= grant;
                        r_state <= StCheck;
                    end
                end
                StCheck: begin
                    if (w_illegal) begin
                        r_err_illegal <= 1'b1;
                        r_state       <= StAccept;
                    end else begin
                        if (r_cur_player) begin
                            r_board_o <= r_board_o | r_grant;
                        end else begin
                            r_board_x <= r_board_x | r_grant;
                        end
                        r_move_idx   <= w_idx;
                        r_move_valid <= 1'b1;
                        r_cur_player <= ~r_cur_player;
                        if (w_full_after) begin
                            r_board_full <= 1'b1;
                            r_state      <= StFull;
                        end else begin
                            r_state <= StAccept;
                        end
                    end
                end
                StFull: begin
                    r_state <= StFull;
                end
                default: begin
                    r_state <= StAccept;
                end
            endcase
        end
    end

    assign grant_ready = (r_state == StAccept);
    assign board_x     = r_board_x;
    assign board_o     = r_board_o;
    assign cur_player  = r_cur_player;
    assign move_idx    = r_move_idx;
    assign move_valid  = r_move_valid;
    assign err_illegal = r_err_illegal;
    assign board_full  = r_board_full;

endmodule
